// File: rtl/microwire_seq.sv
// Microwire (93xx) EEPROM sequencer: one accepted command -> one serial frame, optional ready poll, one rsp_valid pulse.
// Latency 2*CLK_DIV*bits+1 cycles (+CS gap and poll for programming ops); cmd_ready low while a command is in flight.
module microwire_seq #(
  parameter int CLK_DIV = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ee_cs,
  output logic        ee_sk,
  output logic        ee_di,
  input  logic        ee_do
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHIFT_HDR = 3'd1;
  localparam logic [2:0] SHIFT_WR  = 3'd2;
  localparam logic [2:0] SHIFT_RD  = 3'd3;
  localparam logic [2:0] CS_GAP    = 3'd4;
  localparam logic [2:0] POLL      = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [8:0]    PH_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0]    PH_HALF = 9'(CLK_DIV);
  localparam logic [8:0]    PH_GAP  = 9'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [8:0]    ph;
  logic [4:0]    bitn;
  logic [TW-1:0] tcnt;
  logic [24:0]   sreg;
  logic [14:0]   rsh;
  logic          is_rd, has_wr, no_poll, err, up;
  logic          shifting, bit_end;

  assign shifting  = (state == SHIFT_HDR) || (state == SHIFT_WR) || (state == SHIFT_RD);
  assign bit_end   = (ph == PH_LAST);
  assign cmd_ready = up && (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_err   = (state == DONE) && err;
  // Outputs decode straight from state so an async reset drops ee_cs at once.
  assign ee_cs = shifting || (state == POLL);
  assign ee_sk = shifting && (ph >= PH_HALF);
  assign ee_di = ((state == SHIFT_HDR) || (state == SHIFT_WR)) && sreg[24];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ph        <= '0;
      bitn      <= '0;
      tcnt      <= '0;
      sreg      <= '0;
      rsh       <= '0;
      is_rd     <= 1'b0;
      has_wr    <= 1'b0;
      no_poll   <= 1'b0;
      err       <= 1'b0;
      up        <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      up <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state   <= SHIFT_HDR;
            ph      <= '0;
            bitn    <= '0;
            err     <= 1'b0;
            sreg    <= {1'b1, cmd_op, cmd_addr, cmd_wdata};
            is_rd   <= (cmd_op == 2'b10);
            has_wr  <= (cmd_op == 2'b01) || (cmd_op == 2'b00 && cmd_addr[5:4] == 2'b01);
            no_poll <= (cmd_op == 2'b10) ||
                       (cmd_op == 2'b00 && (cmd_addr[5:4] == 2'b11 || cmd_addr[5:4] == 2'b00));
          end
        end
        SHIFT_HDR, SHIFT_WR, SHIFT_RD: begin
          if (bit_end) begin
            ph   <= '0;
            bitn <= bitn + 5'd1;
            sreg <= {sreg[23:0], 1'b0};
            if (state == SHIFT_RD) rsh <= {rsh[13:0], ee_do};
            if (bitn == 5'd8) begin
              // The last header bit doubles as the READ dummy-zero slot.
              if (is_rd) begin
                err   <= ee_do;
                state <= SHIFT_RD;
              end else if (has_wr) state <= SHIFT_WR;
              else if (no_poll)    state <= DONE;
              else                 state <= CS_GAP;
            end else if (bitn == 5'd24) begin
              if (is_rd) begin
                state     <= DONE;
                rsp_rdata <= {rsh, ee_do};
              end else begin
                state <= CS_GAP;
              end
            end
          end else begin
            ph <= ph + 9'd1;
          end
        end
        CS_GAP: begin
          if (ph == PH_GAP) begin
            state <= POLL;
            tcnt  <= '0;
          end else begin
            ph <= ph + 9'd1;
          end
        end
        POLL: begin
          if (ee_do) begin
            state <= DONE;
          end else if (tcnt == T_LAST) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microwire_seq.sv
// Bench for microwire_seq: frame timeline model derived from bit arithmetic, per-cycle compare, directed literal pins.
module tb_microwire_seq;
  localparam int D  = 4;
  localparam int TO = 100;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        ee_do = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err, ee_cs, ee_sk, ee_di;
  logic [15:0] rsp_rdata;

  microwire_seq #(.CLK_DIV(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ee_cs(ee_cs), .ee_sk(ee_sk), .ee_di(ee_di), .ee_do(ee_do));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;

  // pending stimulus, applied just after each rising edge
  bit          p_valid = 0, p_dummy = 0;
  logic [1:0]  p_op = '0;
  logic [5:0]  p_addr = '0;
  logic [15:0] p_wd = '0, p_rdat = '0;
  int          p_busy = 1;

  // model: t = cycles since acceptance (-1 when idle)
  int          t = -1, nb = 9, F = 72, P = 77, L = 1, done_t = 0, m_busy = 1;
  bit          acc = 0, up_m = 0, m_rd = 0, m_wr = 0, m_poll = 0, err_m = 0, m_dummy = 0;
  logic [24:0] bits = '0;
  logic [15:0] m_rdat = '0, rdata_m = '0;
  int          acc_cnt = 0, last_acc = 0, prev_acc = 0;

  // observations of the DUT for the directed literal checks
  int          a_cs = 0, a_gap = 0, a_poll = 0, a_done = -1, a_hdrn = 0;
  logic [8:0]  a_hdr = '0;
  logic        a_err = 1'bx, prev_sk = 1'b0;
  logic [15:0] a_rd = 'x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void plan();
    m_rd    = (p_op == 2'b10);
    m_wr    = (p_op == 2'b01) || (p_op == 2'b00 && p_addr[5:4] == 2'b01);
    m_poll  = !(m_rd || (p_op == 2'b00 && (p_addr[5:4] == 2'b11 || p_addr[5:4] == 2'b00)));
    nb      = (m_rd || m_wr) ? 25 : 9;
    F       = 2 * D * nb;
    P       = F + D + 1;
    L       = (p_busy <= TO) ? p_busy : TO;
    done_t  = m_poll ? P + L : F + 1;
    err_m   = m_rd ? p_dummy : (m_poll && p_busy > TO);
    bits    = {1'b1, p_op, p_addr, p_wd};
    m_rdat  = p_rdat;
    m_dummy = p_dummy;
    m_busy  = p_busy;
  endfunction

  function automatic logic eeprom_do();
    int k, h;
    k = (t - 1) / (2 * D);
    h = (t - 1) % (2 * D);
    if (t >= 1 && m_rd && t <= F && k >= 8 && h >= D)
      return (k == 8) ? m_dummy : m_rdat[15 - (k - 9)];
    if (t >= 1 && m_poll && t >= P && t < P + L)
      return ((t - P) >= m_busy - 1);
    return 1'($urandom);
  endfunction

  task automatic advance();
    cyc++;
    if (acc) begin
      t = 1;
      acc = 0;
    end else if (t >= 0) begin
      t = (t == done_t) ? -1 : t + 1;
    end
    if (t >= 1 && t == done_t && m_rd) rdata_m = m_rdat;
    up_m = rst_n;
  endtask

  task automatic apply();
    cmd_valid = p_valid;
    cmd_op    = p_op;
    cmd_addr  = p_addr;
    cmd_wdata = p_wd;
    ee_do     = eeprom_do();
  endtask

  task automatic compare();
    int  k;
    bit  cs_e, sk_e, di_e, v_e, rdy_e;
    k     = (t - 1) / (2 * D);
    rdy_e = up_m && (t < 0);
    cs_e  = (t >= 1) && (t <= F || (m_poll && t >= P && t < P + L));
    sk_e  = (t >= 1) && (t <= F) && (((t - 1) % (2 * D)) >= D);
    di_e  = (t >= 1) && (t <= F) && (k < ((m_wr) ? 25 : 9)) && bits[24 - k];
    v_e   = (t >= 1) && (t == done_t);
    chk("cmd_ready", cmd_ready, rdy_e);
    chk("ee_cs", ee_cs, cs_e);
    chk("ee_sk", ee_sk, sk_e);
    chk("ee_di", ee_di, di_e);
    chk("rsp_valid", rsp_valid, v_e);
    chk("rsp_rdata", rsp_rdata, rdata_m);
    if (v_e) chk("rsp_err", rsp_err, err_m);
    if (t >= 1) begin
      if (ee_cs) a_cs++;
      if (ee_sk && !prev_sk && a_hdrn < 9) begin
        a_hdr = {a_hdr[7:0], ee_di};
        a_hdrn++;
      end
      if (t > F && !ee_cs && !rsp_valid) a_gap++;
      if (t > F && ee_cs) a_poll++;
      if (rsp_valid) begin
        a_done = t;
        a_err  = rsp_err;
        a_rd   = rsp_rdata;
      end
    end
    prev_sk = ee_sk;
    if (cmd_valid && rdy_e) begin
      acc = 1;
      plan();
      acc_cnt++;
      prev_acc = last_acc;
      last_acc = cyc;
      a_cs = 0; a_gap = 0; a_poll = 0; a_done = -1; a_hdrn = 0;
      a_err = 1'bx; a_rd = 'x;
    end
  endtask

  task automatic step();
    @(posedge clk);
    advance();
    #1 apply();
    @(negedge clk);
    compare();
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [15:0] wd,
                       input logic [15:0] rd, input bit dm, input int busy, input bit keep);
    int c0, n;
    p_op = op; p_addr = addr; p_wd = wd; p_rdat = rd; p_dummy = dm; p_busy = busy;
    p_valid = 1;
    c0 = acc_cnt;
    n = 0;
    do begin
      step();
      n++;
    end while (acc_cnt == c0 && n < 20);
    if (acc_cnt == c0) begin
      errors++;
      $display("FAIL accept_timeout cyc=%0d got=none exp=accept", cyc);
    end
    p_valid = keep;
  endtask

  task automatic finish_cmd();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (t >= 0 && n < 2000);
    if (t >= 0) begin
      errors++;
      $display("FAIL done_timeout cyc=%0d got=busy exp=idle", cyc);
    end
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // READ addr 15, data A5C3, dummy 0
    issue(2'b10, 6'h15, 16'hFFFF, 16'hA5C3, 0, 1, 0);
    finish_cmd();
    chk("rd_hdr", a_hdr, 9'b110010101);
    chk("rd_cs_cycles", a_cs, 200);
    chk("rd_done_cycle", a_done, 201);
    chk("rd_err", a_err, 1'b0);
    chk("rd_data", a_rd, 16'hA5C3);

    // WRITE addr 3F data 1234, ready after 50 poll cycles
    issue(2'b01, 6'h3F, 16'h1234, 16'h0, 0, 50, 0);
    finish_cmd();
    chk("wr_gap", a_gap, 4);
    chk("wr_poll", a_poll, 50);
    chk("wr_done_cycle", a_done, 255);
    chk("wr_err", a_err, 1'b0);

    // ERASE with ee_do stuck low during poll
    issue(2'b11, 6'h0A, 16'h0, 16'h0, 0, 500, 0);
    finish_cmd();
    chk("er_poll", a_poll, 100);
    chk("er_done_cycle", a_done, 177);
    chk("er_err", a_err, 1'b1);

    // EWEN with cmd_valid held: second accept exactly 74 cycles later
    issue(2'b00, 6'h30, 16'h0, 16'h0, 0, 1, 1);
    finish_cmd();
    chk("ewen_done_cycle", a_done, -1);
    chk("ewen_reaccept", last_acc - prev_acc, 74);
    p_valid = 0;
    finish_cmd();
    chk("ewen2_done_cycle", a_done, 73);
    chk("ewen_gap_poll", a_gap + a_poll, 0);

    // READ with bad dummy bit
    issue(2'b10, 6'h01, 16'h0, 16'h5A3C, 1, 1, 0);
    finish_cmd();
    chk("rdbad_err", a_err, 1'b1);
    chk("rdbad_data", a_rd, 16'h5A3C);

    // reset pulse at cycle 40 of a READ
    issue(2'b10, 6'h22, 16'h0, 16'h1111, 0, 1, 0);
    while (t < 39) step();
    @(posedge clk);
    advance();
    #1 apply();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cs_async", ee_cs, 1'b0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 16'h0);
    t = -1; acc = 0; up_m = 0; rdata_m = '0;
    @(negedge clk);
    compare();
    #2 rst_n = 1'b1;
    step();
    chk("rst_ready_after", cmd_ready, 1'b1);
    issue(2'b10, 6'h2C, 16'h0, 16'h0F0F, 0, 1, 0);
    finish_cmd();
    chk("post_rst_done", a_done, 201);
    chk("post_rst_data", a_rd, 16'h0F0F);

    // randomized commands against the model
    for (int i = 0; i < 25; i++) begin
      issue(2'($urandom), 6'($urandom), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0), $urandom_range(1, 130), 0);
      finish_cmd();
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/microwire_seq.md
MICROWIRE_SEQ -- requirements
Module: microwire_seq

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SK half-period; legal range 2..255.
REQ-002 Parameter TIMEOUT, default 20000: maximum clk cycles of ready polling after a programming frame.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port cmd_valid, input, 1: a command is presented.
REQ-006 Port cmd_ready, output, 1: the block can accept a command.
REQ-007 Port cmd_op, input, 2: 93xx opcode; 10=READ, 01=WRITE, 11=ERASE, 00=extended.
REQ-008 Port cmd_addr, input, 6: word address; for op 00, bits [5:4] select 11=EWEN, 00=EWDS, 10=ERAL, 01=WRAL.
REQ-009 Port cmd_wdata, input, 16: write data for WRITE and WRAL.
REQ-010 Port rsp_valid, output, 1: one-cycle completion pulse.
REQ-011 Port rsp_rdata, output, 16: READ result; holds its value until the next READ completes.
REQ-012 Port rsp_err, output, 1: qualified by rsp_valid; 1 means timeout or bad dummy bit.
REQ-013 Ports ee_cs, ee_sk, ee_di, output, 1 each: EEPROM chip select, serial clock and data in.
REQ-014 Port ee_do, input, 1: EEPROM data out; already synchronised externally.

Function
REQ-015 States SHALL be IDLE, SHIFT_HDR, SHIFT_WR, SHIFT_RD, CS_GAP, POLL, DONE.
REQ-016 In IDLE, cmd_ready=1; a command is accepted when cmd_valid=1 and cmd_ready=1; cmd_op/addr/wdata are latched on that edge.
REQ-017 cmd_ready SHALL be 0 from the cycle after acceptance until the cycle after rsp_valid; commands presented meanwhile are ignored.
REQ-018 Bit timing: each serial bit lasts 2*CLK_DIV cycles, with SK low for the first CLK_DIV cycles and high for the last CLK_DIV cycles.
REQ-019 ee_di SHALL change only on the first cycle of an SK-low phase.
REQ-020 ee_do SHALL be sampled only on the last cycle of an SK-high phase.
REQ-021 Acceptance is cycle 0; ee_cs=1 from cycle 1.
REQ-022 Bit k occupies cycles 1+2*CLK_DIV*k through 2*CLK_DIV*(k+1).
REQ-023 SHIFT_HDR SHALL send 9 bits MSB-first: the start bit 1, then cmd_op[1:0], then cmd_addr[5:0].
REQ-024 READ: ee_do sampled at the end of header bit 8 SHALL be 0 (dummy bit); otherwise rsp_err=1 at completion. SHIFT_RD then runs 16 SK pulses and shifts the data in MSB-first.
REQ-025 WRITE/WRAL: SHIFT_WR SHALL send cmd_wdata, 16 bits MSB-first.
REQ-026 End of frame:
- ee_cs=0, ee_sk=0 and ee_di=0 on the first cycle after the last bit.
- READ, EWEN and EWDS go to DONE in that same cycle.
- WRITE, ERASE, ERAL and WRAL go to CS_GAP.
REQ-027 CS_GAP lasts CLK_DIV cycles with ee_cs=0, then goes to POLL.
REQ-028 POLL:
- ee_cs=1 and SK held low.
- ee_do is sampled every cycle; 1 means DONE with rsp_err=0.
- After TIMEOUT cycles without a 1: DONE with rsp_err=1.
REQ-029 DONE lasts exactly one cycle:
- rsp_valid=1; ee_cs=0.
- rsp_rdata updates for READ only.
- The next state is IDLE.
REQ-030 The SK-phase counter and the bit counter SHALL be sized for CLK_DIV=255 and 25 bits without wrap; the TIMEOUT counter saturates.
REQ-031 Back-to-back commands: a command is accepted at the earliest in the cycle after DONE, which guarantees ee_cs low for at least 1 cycle plus CLK_DIV-1 cycles of SK-low lead-in.

Reset
REQ-032 While rst_n=0, outputs SHALL be:
- ee_cs=0, ee_sk=0, ee_di=0
- cmd_ready=0, rsp_valid=0, rsp_err=0
- rsp_rdata=16'h0000
- state=IDLE
REQ-033 cmd_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-034 Reset asserted mid-frame SHALL drop ee_cs immediately (asynchronously), abandon the command and produce no rsp_valid.

Verification
REQ-035 READ, CLK_DIV=4, addr 6'h15, model returns 16'hA5C3 with dummy 0:
- Header bits are 1,1,0,0,1,0,1,0,1.
- ee_cs is high for cycles 1..200.
- rsp_valid at cycle 201 with rsp_rdata=16'hA5C3 and rsp_err=0.
REQ-036 WRITE, addr 6'h3F, data 16'h1234, model busy for 50 cycles:
- 25 bits are sent.
- CS_GAP holds ee_cs low for 4 cycles.
- POLL lasts 50 cycles, then rsp_valid with rsp_err=0.
REQ-037 ERASE with ee_do stuck at 0, TIMEOUT=100: rsp_valid exactly 100 POLL cycles after POLL entry, with rsp_err=1.
REQ-038 EWEN (op 00, addr 6'h30):
- 9-bit frame, no CS_GAP or POLL.
- rsp_valid at cycle 73 with rsp_err=0.
- cmd_valid held high throughout; the second command is accepted at cycle 74 only.
REQ-039 READ with the dummy bit returning 1: rsp_err=1; rsp_rdata updated with the shifted data.
REQ-040 rst_n pulsed low at cycle 40 of a READ:
- ee_cs=0 within the same cycle.
- No rsp_valid.
- cmd_ready=1 one edge after release.
- A following READ completes correctly.
